// File: rtl/key_event_fifo_pkg.sv
// Shared definitions for the key event path: default sizing and key code names.
package key_pkg;

  localparam int NUM_KEYS_DEF = 7;
  localparam int CODE_W_DEF   = 3;

  typedef enum logic [CODE_W_DEF-1:0] {
    KEY0 = 3'd0,
    KEY1 = 3'd1,
    KEY2 = 3'd2,
    KEY3 = 3'd3,
    KEY4 = 3'd4,
    KEY5 = 3'd5,
    KEY6 = 3'd6
  } key_code_e;

endpackage

// File: rtl/key_event_fifo_if.sv
// Valid/ready key event channel between the event FIFO and its consumer.
interface key_event_fifo_if
  import key_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF
) ();

  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_ready;

  modport master (output evt_valid, output evt_code, input evt_ready);
  modport slave  (input evt_valid, input evt_code, output evt_ready);

endinterface

// File: rtl/key_event_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; head data comes straight from registered storage.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/key_event_fifo.sv
// Serializes debounced key press pulses into a prioritized, buffered stream of key codes.
module key_event_fifo
  import key_pkg::*;
#(
  parameter int NUM_KEYS = NUM_KEYS_DEF,
  parameter int CODE_W   = CODE_W_DEF,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_KEYS-1:0]      key_flag,
  key_event_fifo_if.master         evt,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               drop_cnt
);

  logic [NUM_KEYS-1:0] pend;
  logic [NUM_KEYS-1:0] grant;
  logic [CODE_W-1:0]   grant_code;
  logic                found;
  logic                push;
  logic                push_ok;
  logic                pop;
  logic                merge;
  logic                full;
  logic                empty;
  logic [CODE_W-1:0]   head_code;

  assign pop     = evt.evt_valid & evt.evt_ready;
  assign push_ok = ~full | pop;

  // Lowest-index pending key wins; grant stays clear when no slot is available.
  always_comb begin
    grant      = '0;
    grant_code = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      if (pend[i] && !found) begin
        found      = 1'b1;
        grant_code = CODE_W'(i);
        grant[i]   = push_ok;
      end
    end
  end

  assign push  = |grant;
  assign merge = |(key_flag & pend & ~grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= '0;
      drop_cnt <= '0;
    end else begin
      pend <= (pend & ~grant) | key_flag;
      if (merge && drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (grant_code),
    .pop   (pop),
    .rdata (head_code),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign evt.evt_valid = ~empty;
  assign evt.evt_code  = empty ? '0 : head_code;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo: latency, ordering, full hold, merge counting, reset.
module tb_key_event_fifo;

  logic       clk;
  logic       rst;
  logic [6:0] key_flag;
  logic [3:0] fifo_level;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int fill9 [9] = '{0, 1, 2, 3, 4, 5, 6, 0, 0};
  int fill8 [8] = '{0, 1, 2, 3, 4, 5, 6, 0};
  int seq4  [8] = '{1, 2, 3, 4, 5, 6, 0, 0};
  int seq5  [9] = '{0, 1, 2, 3, 4, 5, 6, 0, 3};

  key_event_fifo_if #(.CODE_W(3)) evt_if ();

  key_event_fifo #(
    .NUM_KEYS (7),
    .CODE_W   (3),
    .DEPTH    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_flag   (key_flag),
    .evt        (evt_if.master),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish within 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst              = 1'b1;
    key_flag         = '0;
    evt_if.evt_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_valid", evt_if.evt_valid, 0);
    check("reset_code",  evt_if.evt_code,  0);
    check("reset_level", fifo_level,       0);
    check("reset_drop",  drop_cnt,         0);

    // Single press, fast consumer
    key_flag         = 7'b0000100;
    evt_if.evt_ready = 1'b1;
    tick();
    key_flag = '0;
    check("single_lat1_valid", evt_if.evt_valid, 0);
    tick();
    check("single_valid", evt_if.evt_valid, 1);
    check("single_code",  evt_if.evt_code,  2);
    check("single_level", fifo_level,       1);
    tick();
    check("single_after_valid", evt_if.evt_valid, 0);
    check("single_after_level", fifo_level,       0);
    check("single_drop",        drop_cnt,         0);

    // Simultaneous press, ascending order
    evt_if.evt_ready = 1'b0;
    key_flag         = 7'b1010010;
    tick();
    key_flag = '0;
    tick(); tick(); tick();
    check("simul_level", fifo_level,      3);
    check("simul_head",  evt_if.evt_code, 1);
    tick();
    check("simul_hold_code",  evt_if.evt_code,  1);
    check("simul_hold_level", fifo_level,       3);
    evt_if.evt_ready = 1'b1;
    check("simul_pop0", evt_if.evt_code, 1);
    tick();
    check("simul_pop1", evt_if.evt_code, 4);
    tick();
    check("simul_pop2", evt_if.evt_code, 6);
    tick();
    check("simul_empty", evt_if.evt_valid, 0);
    check("simul_level0", fifo_level,      0);

    // Full FIFO hold, then push+pop at full
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      key_flag = 7'(1 << fill9[i]);
      tick();
    end
    key_flag = '0;
    tick(); tick();
    check("full_level", fifo_level,       8);
    check("full_drop",  drop_cnt,         0);
    check("full_valid", evt_if.evt_valid, 1);
    check("full_head",  evt_if.evt_code,  0);
    evt_if.evt_ready = 1'b1;
    tick();
    evt_if.evt_ready = 1'b0;
    check("pushpop_level", fifo_level,      8);
    check("pushpop_head",  evt_if.evt_code, 1);
    tick();
    check("pushpop_level_hold", fifo_level, 8);
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain4_valid", evt_if.evt_valid, 1);
      check("drain4_code",  evt_if.evt_code,  seq4[i]);
      tick();
    end
    check("drain4_empty", evt_if.evt_valid, 0);
    check("drain4_level", fifo_level,       0);
    check("drain4_drop",  drop_cnt,         0);

    // Merge while full, then saturation
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      key_flag = 7'(1 << fill8[i]);
      tick();
    end
    key_flag = '0;
    tick(); tick();
    check("merge_full_level", fifo_level, 8);
    key_flag = 7'b0001000;
    tick();
    key_flag = '0;
    tick();
    check("merge_first_nodrop", drop_cnt, 0);
    key_flag = 7'b0001000;
    tick();
    key_flag = '0;
    tick();
    check("merge_drop1", drop_cnt, 1);
    for (int i = 0; i < 300; i++) begin
      key_flag = 7'b0001000;
      tick();
    end
    key_flag = '0;
    tick();
    check("merge_sat",       drop_cnt,   255);
    check("merge_sat_level", fifo_level, 8);
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check("drain5_valid", evt_if.evt_valid, 1);
      check("drain5_code",  evt_if.evt_code,  seq5[i]);
      tick();
    end
    check("drain5_empty", evt_if.evt_valid, 0);
    tick(); tick(); tick();
    check("drain5_single3", evt_if.evt_valid, 0);
    check("drain5_drop",    drop_cnt,         255);

    // Reset mid-operation with flags asserted during reset
    evt_if.evt_ready = 1'b0;
    key_flag         = 7'b0111111;
    tick();
    key_flag = '0;
    tick(); tick(); tick(); tick(); tick();
    check("rstmid_level", fifo_level, 5);
    rst      = 1'b1;
    key_flag = 7'h7F;
    tick();
    rst      = 1'b0;
    key_flag = '0;
    check("rstmid_valid", evt_if.evt_valid, 0);
    check("rstmid_level0", fifo_level,      0);
    check("rstmid_drop",  drop_cnt,         0);
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstmid_no_events", evt_if.evt_valid, 0);
    end
    check("rstmid_level_end", fifo_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
